// File: rtl/line_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// line_ram_arbiter_if
// Requester-side bundle for one port of the luma line RAM arbiter.
// One instance per requester (intra_pred_fsm, deblocking filter).
//
// Signals
//   req     requester -> arbiter  access wanted this cycle
//   lock    requester -> arbiter  keep ownership next cycle (burst)
//   wr_n    requester -> arbiter  0 = write, 1 = read
//   addr    requester -> arbiter  line RAM word address
//   wdata   requester -> arbiter  write data
//   gnt     arbiter -> requester  access performed this cycle (combinational)
//   rvalid  arbiter -> requester  shared ram_rdata carries this port's read
//
// Modports
//   master  requester view
//   slave   arbiter view
// ----------------------------------------------------------------------------
interface line_ram_arbiter_if #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
);
  logic                 req;
  logic                 lock;
  logic                 wr_n;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] wdata;
  logic                 gnt;
  logic                 rvalid;

  modport master (
    output req, lock, wr_n, addr, wdata,
    input  gnt, rvalid
  );

  modport slave (
    input  req, lock, wr_n, addr, wdata,
    output gnt, rvalid
  );
endinterface

// File: rtl/line_ram_arbiter.sv
// ----------------------------------------------------------------------------
// line_ram_arbiter
// Shares the single-port luma line RAM (upper-row pixel store) between
// port A (intra_pred_fsm preload reads / write-back) and port B (deblocking
// filter). Fixed priority to A, a starvation guard for B, and burst locking
// so that a multi-word preload is not split.
//
// Ports
//   clk        clock
//   rst_n      synchronous reset, active low; forces RAM strobes idle
//   ena        global enable; low freezes arbitration state
//   a_port     requester A (slave modport of line_ram_arbiter_if)
//   b_port     requester B (slave modport of line_ram_arbiter_if)
//   ram_addr   RAM address (holds last granted address when idle)
//   ram_wr_n   RAM write strobe, active low
//   ram_wdata  RAM write data (holds last granted data when idle)
//
// Owner states
//   state    | meaning
//   OWN_NONE | no burst in progress, plain priority arbitration
//   OWN_A    | A holds a lock; A wins while it requests and budget remains
//   OWN_B    | B holds a lock; B wins while it requests and budget remains
// ----------------------------------------------------------------------------
module line_ram_arbiter #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_LOCK  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  line_ram_arbiter_if.slave    a_port,
  line_ram_arbiter_if.slave    b_port,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_wr_n,
  output logic [DATA_BITS-1:0] ram_wdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int LOCK_W = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(MAX_WAIT);
  localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(MAX_LOCK);
  // A fresh lock has already consumed one grant of its budget.
  localparam logic [LOCK_W-1:0] LOCK_FIRST = LOCK_W'((MAX_LOCK > 0) ? MAX_LOCK - 1 : 0);

  logic [1:0]           owner;
  // Down-counters: wait_left reaching zero means B has waited MAX_WAIT
  // cycles; lock_left reaching zero means the lock budget is spent.
  logic [WAIT_W-1:0]    wait_left;
  logic [LOCK_W-1:0]    lock_left;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;

  logic lock_live;
  logic own_a_hit;
  logic own_b_hit;
  logic starve;
  logic gnt_a;
  logic gnt_b;
  logic gnt_own;
  logic gnt_lock;

  assign lock_live = (lock_left != '0);
  assign own_a_hit = (owner == OWN_A) && a_port.req && lock_live;
  assign own_b_hit = (owner == OWN_B) && b_port.req && lock_live;
  assign starve    = b_port.req && (wait_left == '0);

  // Priority order: live lock owner, starving B, A, B. A live A lock sits
  // above the starvation override so a burst is never pre-empted.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n && ena) begin
      if (own_a_hit)        gnt_a = 1'b1;
      else if (own_b_hit)   gnt_b = 1'b1;
      else if (starve)      gnt_b = 1'b1;
      else if (a_port.req)  gnt_a = 1'b1;
      else if (b_port.req)  gnt_b = 1'b1;
    end
  end

  // Grant came through the lock path (continuing burst) rather than fresh
  // arbitration; only then does the lock budget keep counting down.
  assign gnt_own  = rst_n && ena && (own_a_hit || own_b_hit);
  assign gnt_lock = (gnt_a && a_port.lock) || (gnt_b && b_port.lock);

  assign a_port.gnt = gnt_a;
  assign b_port.gnt = gnt_b;

  always_comb begin
    ram_wr_n  = 1'b1;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (!rst_n) begin
      ram_addr  = '0;
      ram_wdata = '0;
    end else if (gnt_a) begin
      ram_wr_n  = a_port.wr_n;
      ram_addr  = a_port.addr;
      ram_wdata = a_port.wdata;
    end else if (gnt_b) begin
      ram_wr_n  = b_port.wr_n;
      ram_addr  = b_port.addr;
      ram_wdata = b_port.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner         <= OWN_NONE;
      wait_left     <= WAIT_LOAD;
      lock_left     <= LOCK_LOAD;
      addr_q        <= '0;
      wdata_q       <= '0;
      a_port.rvalid <= 1'b0;
      b_port.rvalid <= 1'b0;
    end else begin
      // Read data returns one cycle after the access, independent of ena.
      a_port.rvalid <= gnt_a && a_port.wr_n;
      b_port.rvalid <= gnt_b && b_port.wr_n;

      if (gnt_a || gnt_b) begin
        addr_q  <= ram_addr;
        wdata_q <= ram_wdata;
      end

      if (ena) begin
        if (gnt_lock) begin
          owner     <= gnt_a ? OWN_A : OWN_B;
          lock_left <= gnt_own ? lock_left - LOCK_W'(1) : LOCK_FIRST;
        end else begin
          owner     <= OWN_NONE;
          lock_left <= LOCK_LOAD;
        end

        if (gnt_b || !b_port.req) begin
          wait_left <= WAIT_LOAD;
        end else if (wait_left != '0) begin
          wait_left <= wait_left - WAIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_line_ram_arbiter.sv
module tb_line_ram_arbiter;
  localparam int AB = 10;
  localparam int DB = 32;
  localparam int MW = 4;
  localparam int ML = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  always #5 clk = ~clk;

  line_ram_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) a_if ();
  line_ram_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) b_if ();

  logic [AB-1:0] ram_addr;
  logic          ram_wr_n;
  logic [DB-1:0] ram_wdata;

  line_ram_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .MAX_WAIT(MW), .MAX_LOCK(ML)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .a_port   (a_if.slave),
    .b_port   (b_if.slave),
    .ram_addr (ram_addr),
    .ram_wr_n (ram_wr_n),
    .ram_wdata(ram_wdata)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_a  = 0;
  int cnt_b  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic          ga;
    logic          gb;
    logic          wr_n;
    logic          arv;
    logic          brv;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model, written from the behavioural description with up-counters.
  int            m_owner;
  int            m_wait;
  int            m_lcnt;
  logic          m_arv;
  logic          m_brv;
  logic [AB-1:0] m_addr;
  logic [DB-1:0] m_wdata;
  logic          e_ga;
  logic          e_gb;
  logic          e_own;

  task automatic model_reset();
    m_owner = 0;
    m_wait  = 0;
    m_lcnt  = 0;
    m_arv   = 1'b0;
    m_brv   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
  endtask

  task automatic model_comb();
    e_ga  = 1'b0;
    e_gb  = 1'b0;
    e_own = 1'b0;
    if (rst_n && ena) begin
      if (m_owner == 1 && a_if.req && m_lcnt < ML) begin
        e_ga = 1'b1; e_own = 1'b1;
      end else if (m_owner == 2 && b_if.req && m_lcnt < ML) begin
        e_gb = 1'b1; e_own = 1'b1;
      end else if (b_if.req && m_wait >= MW) e_gb = 1'b1;
      else if (a_if.req) e_ga = 1'b1;
      else if (b_if.req) e_gb = 1'b1;
    end
  endtask

  task automatic model_seq();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_arv = e_ga && a_if.wr_n;
      m_brv = e_gb && b_if.wr_n;
      if (e_ga) begin
        m_addr = a_if.addr; m_wdata = a_if.wdata;
      end else if (e_gb) begin
        m_addr = b_if.addr; m_wdata = b_if.wdata;
      end
      if (ena) begin
        if ((e_ga && a_if.lock) || (e_gb && b_if.lock)) begin
          m_owner = e_ga ? 1 : 2;
          m_lcnt  = e_own ? m_lcnt + 1 : 1;
        end else begin
          m_owner = 0;
          m_lcnt  = 0;
        end
        if (e_gb || !b_if.req) m_wait = 0;
        else if (m_wait < MW) m_wait++;
      end
    end
  endtask

  // Inputs are already applied (posedge + 1); predict this cycle, sample at negedge.
  task automatic tick();
    exp_t e;
    model_comb();
    e.ga    = e_ga;
    e.gb    = e_gb;
    e.arv   = m_arv;
    e.brv   = m_brv;
    e.wr_n  = e_ga ? a_if.wr_n : (e_gb ? b_if.wr_n : 1'b1);
    e.addr  = !rst_n ? '0 : (e_ga ? a_if.addr  : (e_gb ? b_if.addr  : m_addr));
    e.wdata = !rst_n ? '0 : (e_ga ? a_if.wdata : (e_gb ? b_if.wdata : m_wdata));
    exp_q.push_back(e);
    @(posedge clk);
    model_seq();
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("a_gnt",     64'(a_if.gnt),    64'(mon_e.ga));
      check("b_gnt",     64'(b_if.gnt),    64'(mon_e.gb));
      check("gnt_excl",  64'(a_if.gnt & b_if.gnt), 64'(0));
      check("ram_wr_n",  64'(ram_wr_n),    64'(mon_e.wr_n));
      check("ram_addr",  64'(ram_addr),    64'(mon_e.addr));
      check("ram_wdata", 64'(ram_wdata),   64'(mon_e.wdata));
      check("a_rvalid",  64'(a_if.rvalid), 64'(mon_e.arv));
      check("b_rvalid",  64'(b_if.rvalid), 64'(mon_e.brv));
      if (a_if.gnt === 1'b1) cnt_a++;
      if (b_if.gnt === 1'b1) cnt_b++;
    end
  end

  task automatic set_a(input logic req, input logic lock, input logic wr_n,
                       input logic [AB-1:0] addr, input logic [DB-1:0] wdata);
    a_if.req = req; a_if.lock = lock; a_if.wr_n = wr_n; a_if.addr = addr; a_if.wdata = wdata;
  endtask

  task automatic set_b(input logic req, input logic lock, input logic wr_n,
                       input logic [AB-1:0] addr, input logic [DB-1:0] wdata);
    b_if.req = req; b_if.lock = lock; b_if.wr_n = wr_n; b_if.addr = addr; b_if.wdata = wdata;
  endtask

  task automatic idle(input int n);
    set_a(1'b0, 1'b0, 1'b1, '0, '0);
    set_b(1'b0, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  int ca, cb;

  initial begin
    model_reset();
    set_a(1'b0, 1'b0, 1'b1, '0, '0);
    set_b(1'b0, 1'b0, 1'b1, '0, '0);
    rst_n = 1'b0;
    ena   = 1'b1;
    @(posedge clk);
    #1;

    // Reset with requests present: outputs forced idle.
    set_a(1'b1, 1'b1, 1'b0, 10'h155, 32'hdead_beef);
    set_b(1'b1, 1'b0, 1'b1, 10'h0aa, 32'h1234_5678);
    tick();
    tick();
    rst_n = 1'b1;
    idle(2);

    // A read burst, lock for 4 cycles.
    ca = cnt_a; cb = cnt_b;
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b1, 1'b1, 10'(16 + i), 32'(i));
      tick();
    end
    check("burst_a_cnt", 64'(cnt_a - ca), 64'(4));
    check("burst_b_cnt", 64'(cnt_b - cb), 64'(0));
    idle(2);

    // A and B together, no locks: four A grants, then starvation override.
    ca = cnt_a; cb = cnt_b;
    for (int i = 0; i < 5; i++) begin
      set_a(1'b1, 1'b0, 1'b0, 10'(32 + i), 32'hA000_0000 + 32'(i));
      set_b(1'b1, 1'b0, 1'b1, 10'(64 + i), 32'hB000_0000 + 32'(i));
      tick();
      if (i == 3) begin
        check("starve_a_cnt", 64'(cnt_a - ca), 64'(4));
        check("starve_b_pre", 64'(cnt_b - cb), 64'(0));
      end
    end
    check("starve_b_cnt", 64'(cnt_b - cb), 64'(1));
    idle(2);

    // B owns a lock; A must wait until B releases.
    set_b(1'b1, 1'b1, 1'b0, 10'h200, 32'h0000_b0b0);
    tick();
    ca = cnt_a;
    for (int i = 0; i < 3; i++) begin
      set_a(1'b1, 1'b0, 1'b1, 10'h300, 32'h0);
      set_b(1'b1, 1'b1, 1'b0, 10'(10'h201 + i), 32'(i));
      tick();
    end
    check("block_a_wait", 64'(cnt_a - ca), 64'(0));
    set_b(1'b1, 1'b0, 1'b0, 10'h204, 32'h4);
    tick();
    tick();
    check("block_a_after", 64'(cnt_a - ca), 64'(1));
    idle(2);

    // A lock held for 10 cycles with B requesting: lock budget runs out after 8.
    ca = cnt_a; cb = cnt_b;
    for (int i = 0; i < 10; i++) begin
      set_a(1'b1, 1'b1, 1'b1, 10'(i), 32'(i));
      set_b(1'b1, 1'b0, 1'b0, 10'h3f0, 32'hcafe_0000 + 32'(i));
      tick();
      if (i == 7) begin
        check("maxlock_a_cnt", 64'(cnt_a - ca), 64'(8));
        check("maxlock_b_pre", 64'(cnt_b - cb), 64'(0));
      end
      if (i == 8) check("maxlock_b_cnt", 64'(cnt_b - cb), 64'(1));
    end
    idle(2);

    // ena low for 3 cycles inside an A write burst.
    for (int i = 0; i < 2; i++) begin
      set_a(1'b1, 1'b1, 1'b0, 10'(10'h100 + i), 32'h5500_0000 + 32'(i));
      tick();
    end
    ca = cnt_a;
    ena = 1'b0;
    set_b(1'b1, 1'b0, 1'b1, 10'h111, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check("ena_off_a", 64'(cnt_a - ca), 64'(0));
    ena = 1'b1;
    for (int i = 2; i < 4; i++) begin
      set_a(1'b1, 1'b1, 1'b0, 10'(10'h100 + i), 32'h5500_0000 + 32'(i));
      tick();
    end
    check("ena_resume_a", 64'(cnt_a - ca), 64'(2));
    idle(2);

    // Reset during a B write burst aborts ownership.
    for (int i = 0; i < 2; i++) begin
      set_b(1'b1, 1'b1, 1'b0, 10'(10'h080 + i), 32'h7700_0000 + 32'(i));
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ca = cnt_a;
    set_a(1'b1, 1'b0, 1'b1, 10'h0c0, 32'h0);
    set_b(1'b1, 1'b1, 1'b0, 10'h082, 32'h7700_0002);
    tick();
    check("rst_owner_none", 64'(cnt_a - ca), 64'(1));
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_a(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            10'($urandom), $urandom);
      set_b(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
            10'($urandom), $urandom);
      ena   = 1'($urandom_range(0, 7) != 0);
      rst_n = 1'($urandom_range(0, 60) != 0);
      tick();
    end
    rst_n = 1'b1;
    ena   = 1'b1;
    idle(2);

    check("sb_drain", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
